// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: receive-side decoder for a multiplexed two-digit,
// active-low seven-segment scan bus (gfedcba + two digit enables).
// Recovers tens/ones BCD digits and their binary value, flags illegal
// patterns (seg_err) and a stalled scan (scan_timeout).
// Optional build macro SSD_CHANGE_ONLY_EN: when defined, update pulses only
// when the published value changes, or on the first publish after reset or
// after a timeout. When undefined, update pulses on every publish.
//
// Handshake: the outputs form a one-way valid stream. update is a one-cycle
// strobe that marks the cycle where tens_out/ones_out/value_bin have just
// reloaded. value_valid is a level that is high while the published value is
// current and the scan is alive. There is no ready; the consumer must sample
// on the update strobe.
module ssd_scan_decoder #(
    parameter int SETTLE_CYC  = 1000,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int MAX_TENS    = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [6:0] hex_in,
    input  logic       en1_in,
    input  logic       en2_in,
    output logic [3:0] tens_out,
    output logic [3:0] ones_out,
    output logic [5:0] value_bin,
    output logic       value_valid,
    output logic       update,
    output logic       seg_err,
    output logic       scan_timeout
);

    localparam int SW = $clog2(SETTLE_CYC + 2);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, HAVE_T, HAVE_O} state_t;

    state_t        state, state_nxt;
    logic [8:0]    sync1, sync2, prev;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] wd_cnt;
    logic [3:0]    tens_h, ones_h;
    logic [3:0]    digit;
    logic          legal;
    logic          is_tens, is_ones;
    logic          settled, capture, reject, accept, wd_hit;
    logic          load_t, load_o, publish;
    logic [3:0]    pub_tens, pub_ones;
    logic [5:0]    pub_value;
`ifdef SSD_CHANGE_ONLY_EN
    logic          first_pub;
`endif

    // Two-flop synchronizer on the 9-bit bus, plus a delayed copy for change detection.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {en1_in, en2_in, hex_in};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign is_tens = sync2[8] & ~sync2[7];
    assign is_ones = ~sync2[8] & sync2[7];

    // Settle counter: restarts on any pattern change, saturates one past the
    // threshold so a steady pattern is captured exactly once.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            settle_cnt <= '0;
        end else if (sync2 != prev) begin
            settle_cnt <= '0;
        end else if (settle_cnt != SW'(SETTLE_CYC + 1)) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    // The equality guard stops a count still running from the old pattern
    // from capturing the first cycle of a new one.
    assign settled = (settle_cnt == SW'(SETTLE_CYC)) && (sync2 == prev);
    assign capture = settled && (is_tens || is_ones);

    // Active-low gfedcba to BCD digit; anything not in the table is illegal.
    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (sync2[6:0])
            7'b1000000: digit = 4'd0;
            7'b1111001: digit = 4'd1;
            7'b0100100: digit = 4'd2;
            7'b0110000: digit = 4'd3;
            7'b0011001: digit = 4'd4;
            7'b0010010: digit = 4'd5;
            7'b0000010: digit = 4'd6;
            7'b1111000: digit = 4'd7;
            7'b0000000: digit = 4'd8;
            7'b0010000: digit = 4'd9;
            default:    legal = 1'b0;
        endcase
    end

    assign reject = capture && (!legal || (is_tens && (digit > 4'(MAX_TENS))));
    assign accept = capture && !reject;

    // Watchdog: cleared by any capture, saturates so the threshold hits once.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (capture) begin
            wd_cnt <= '0;
        end else if (wd_cnt != TW'(TIMEOUT_CYC)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_hit = (wd_cnt == TW'(TIMEOUT_CYC - 1));

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Pairing FSM: hold one digit until the other phase arrives, then publish.
    always_comb begin
        state_nxt = state;
        load_t    = 1'b0;
        load_o    = 1'b0;
        publish   = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (is_tens) begin load_t = 1'b1; state_nxt = HAVE_T; end
                    else         begin load_o = 1'b1; state_nxt = HAVE_O; end
                end
                HAVE_T: begin
                    if (is_ones) begin publish = 1'b1; state_nxt = IDLE; end
                    else         load_t = 1'b1;
                end
                HAVE_O: begin
                    if (is_tens) begin publish = 1'b1; state_nxt = IDLE; end
                    else         load_o = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (reject || wd_hit) begin
            state_nxt = IDLE;
        end
    end

    assign pub_tens  = is_tens ? digit : tens_h;
    assign pub_ones  = is_ones ? digit : ones_h;
    assign pub_value = ({2'b00, pub_tens} << 3) + ({2'b00, pub_tens} << 1) + {2'b00, pub_ones};

    // Held digits, published outputs, strobes and the timeout level.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            tens_h       <= '0;
            ones_h       <= '0;
            tens_out     <= '0;
            ones_out     <= '0;
            value_bin    <= '0;
            value_valid  <= 1'b0;
            update       <= 1'b0;
            seg_err      <= 1'b0;
            scan_timeout <= 1'b0;
`ifdef SSD_CHANGE_ONLY_EN
            first_pub    <= 1'b1;
`endif
        end else begin
            update  <= 1'b0;
            seg_err <= reject;
            if (load_t) tens_h <= digit;
            if (load_o) ones_h <= digit;
            if (publish) begin
                tens_out    <= pub_tens;
                ones_out    <= pub_ones;
                value_bin   <= pub_value;
                value_valid <= 1'b1;
`ifdef SSD_CHANGE_ONLY_EN
                update      <= first_pub || (pub_value != value_bin);
                first_pub   <= 1'b0;
`else
                update      <= 1'b1;
`endif
            end
            if (accept) begin
                scan_timeout <= 1'b0;
            end else if (wd_hit) begin
                scan_timeout <= 1'b1;
                value_valid  <= 1'b0;
`ifdef SSD_CHANGE_ONLY_EN
                first_pub    <= 1'b1;
`endif
            end
        end
    end

endmodule
